param_updown_counter: RTL
=========================

// Module: param_updown_counter
// PURPOSE
//   Parametrised successor to the fixed 4-bit binary counter. Provides a
//   WIDTH-bit up/down counter with programmable modulus, synchronous load,
//   count enable and an optional prescaler. Wrap and saturate modes are both
//   supported. Used as the general-purpose counter/timebase for the
//   board-level designs in this codebase.
// PARAMETERS
//   WIDTH     4    counter width in bits (>=1)
//   MAX_VAL   15   terminal value; count range 0..MAX_VAL (<= 2**WIDTH-1)
//   PRESCALE  1    number of enabled cycles per count step (>=1; 1 = no prescale)
//   SATURATE  0    0 = wrap at the range ends; 1 = hold at the range ends
// PORTS
//   Clk      in   1      clock; all state updates on the rising edge
//   Reset    in   1      synchronous, active-high reset
//   En       in   1      count enable; also gates the prescaler
//   Up       in   1      1 = count up, 0 = count down; sampled on the step cycle
//   Load     in   1      synchronous load strobe
//   LoadVal  in   WIDTH  value loaded when Load=1
//   Q        out  WIDTH  current count (registered)
//   TC       out  1      combinational terminal count: (Up & Q==MAX_VAL) | (~Up & Q==0)
//   Wrap     out  1      registered 1-cycle pulse when a step wraps around the range
//   Sat      out  1      registered level, high while a step is blocked at a limit (SATURATE=1)
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high. Clock port is
//     Clk; reset port is Reset.
//   - Reset: Q=0, Wrap=0, Sat=0, prescaler count=0.
//   - Priority within a cycle: Reset > Load > step > hold.
//   - Load: Q <= min(LoadVal, MAX_VAL); prescaler count <= 0; Wrap <= 0;
//     Sat <= 0. Load takes effect whether or not En is high.
//   - Prescaler: a counter pc in 0..PRESCALE-1 increments on each cycle with
//     En=1. A step occurs on an En=1 cycle when pc==PRESCALE-1; pc then returns
//     to 0. When En=0, pc and Q hold. With PRESCALE=1, every En=1 cycle is a
//     step.
//   - Step, Up=1:
//       Q<MAX_VAL -> Q+1.
//       Q==MAX_VAL -> Q=0 with Wrap=1 (SATURATE=0), or Q holds with Sat=1
//       (SATURATE=1).
//   - Step, Up=0:
//       Q>0 -> Q-1.
//       Q==0 -> Q=MAX_VAL with Wrap=1 (SATURATE=0), or Q holds with Sat=1
//       (SATURATE=1).
//   - Wrap is high for exactly the cycle after the wrapping edge and low
//     otherwise.
//   - Sat is updated on every step: set when the step was blocked, cleared
//     when the step moved Q. It holds between steps and is cleared by Load
//     and Reset.
//   - Latency: Q changes on the clock edge of the step cycle, so it is visible
//     1 cycle after the step. TC follows Q and Up combinationally with zero
//     latency.
//   - Arithmetic: modulo MAX_VAL+1, not modulo 2**WIDTH. No X states; Q never
//     exceeds MAX_VAL.
//   - Up may change on any cycle. Only its value on a step cycle matters.
//   - Reset asserted mid-prescale or alongside Load: Reset wins, and all state
//     returns to its reset values on that edge.
// TESTING
//   1. W=4, MAX=15, PRESCALE=1: Reset, then En=1 Up=1 for 17 cycles ->
//      Q goes 0..15, 0, 1; Wrap=1 exactly once (the cycle after 15->0);
//      TC=1 while Q=15.
//   2. W=4, MAX=9: Load=1 LoadVal=12 -> Q=9. Then Up=0 for 11 steps ->
//      Q goes 8..0, 9, 8; Wrap pulses after 0->9.
//   3. SATURATE=1, MAX=9: Q=9, Up=1 for 3 steps -> Q stays 9, Sat=1.
//      Then Up=0 for 1 step -> Q=8, Sat=0.
//   4. PRESCALE=4: En=1 for 12 cycles with En=0 inserted at cycle 5 -> Q steps
//      only on every 4th enabled cycle, reaching Q=2 after 12 cycles (11
//      enabled); pc holds while En=0.
//   5. Load and step in the same cycle (Load=1, LoadVal=3, En=1 at pc=3) ->
//      Q=3, pc=0, no Wrap. Next step occurs 4 enabled cycles later.
//   6. Reset=1 asserted together with Load=1 at Q=7, pc=2 -> Q=0, pc=0,
//      Wrap=0, Sat=0 on the next edge.

Source files
------------

// File: rtl/param_updown_counter.sv
// param_updown_counter: WIDTH-bit up/down counter with modulus, load, enable, prescaler and wrap/saturate modes
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap,
    output logic             Sat
);
    localparam int               PW       = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0]    PC_LAST  = PW'(PRESCALE - 1);
    localparam logic             SAT_MODE = SATURATE != 0;

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pc;
    logic             r_wrap;
    logic             r_sat;
    logic             w_step;
    logic             w_limit;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_load_q;

    // step decode, next count at the range ends, and load clamp to the modulus
    always_comb begin
        w_step   = En && (r_pc == PC_LAST);
        w_limit  = Up ? (r_q == MAX_Q) : (r_q == '0);
        w_next_q = w_limit ? (SAT_MODE ? r_q : (Up ? '0 : MAX_Q)) : (Up ? r_q + 1'b1 : r_q - 1'b1);
        w_load_q = (LoadVal > MAX_Q) ? MAX_Q : LoadVal;
    end

    // state update: reset beats load beats step; wrap is a one-cycle pulse, sat only moves on steps
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q    <= '0;
            r_pc   <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (Load) begin
            r_q    <= w_load_q;
            r_pc   <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_wrap <= w_step && w_limit && !SAT_MODE;
            if (En)
                r_pc <= w_step ? '0 : r_pc + 1'b1;
            if (w_step) begin
                r_q   <= w_next_q;
                r_sat <= w_limit && SAT_MODE;
            end
        end
    end

    assign Q    = r_q;
    assign TC   = Up ? (r_q == MAX_Q) : (r_q == '0);
    assign Wrap = r_wrap;
    assign Sat  = r_sat;
endmodule
